// File: rtl/mips_defs_pkg.sv
// Shared definitions for the multicycle MIPS instruction-memory slice:
// default word width, default NOP encoding, control state encoding and
// the registered fetch-response flags.
package mips_defs;

  localparam int          MIPS_DATA_W   = 32;
  localparam logic [31:0] MIPS_NOP_WORD = 32'h0000_0000;

  // LOAD accepts program words, RUN serves fetches; never both.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  // Decoded outcome of an accepted fetch, captured alongside the RAM read.
  typedef struct packed {
    logic hit;  // slot is in range, aligned and loaded: use RAM data
    logic err;  // misaligned or beyond DEPTH
  } fetch_rsp_t;

endpackage

// File: rtl/instr_mem_array.sv
// Single-write-port, single-registered-read-port RAM, DEPTH x DATA_W.
// No reset anywhere so the storage and read register map onto block RAM.
module instr_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; rdata only moves on a read so it holds between fetches.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: word-serial program load in LOAD state,
// 1-cycle registered fetch with alignment/range checks in RUN state.
module instr_mem_loadable
  import mips_defs::*;
#(
  parameter int                DATA_W   = MIPS_DATA_W,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP_WORD),
  localparam int               PL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              restart,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_err,
  output logic [PL_W-1:0]   prog_len,
  output logic              running
);

  localparam int MA_W   = $clog2(DEPTH);
  localparam int STAGES = 1;

  imem_state_e       state;
  logic [PL_W-1:0]   wptr;
  logic [PL_W-1:0]   wptr_inc;
  logic [STAGES-1:0] vld_pipe;
  fetch_rsp_t        rsp_d, rsp_q;
  logic [ADDR_W-1:0] idx;
  logic              load_fire, fetch_fire, last_beat;
  logic [DATA_W-1:0] rdata;

  // restart wins over both handshakes on the same cycle.
  assign load_fire  = load_valid && load_ready && !restart;
  assign fetch_fire = fetch_req && fetch_ready && !restart;
  assign wptr_inc   = wptr + PL_W'(1);
  assign last_beat  = load_last || (wptr_inc == PL_W'(DEPTH));

  // Classify the requested address against alignment, DEPTH and loaded length.
  always_comb begin
    idx       = fetch_addr >> 2;
    rsp_d.err = (fetch_addr[1:0] != 2'b00) || (idx >= ADDR_W'(DEPTH));
    rsp_d.hit = !rsp_d.err && (idx < ADDR_W'(wptr));
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MA_W)
  ) u_array (
    .clk   (clk),
    .we    (load_fire),
    .waddr (wptr[MA_W-1:0]),
    .wdata (load_data),
    .re    (fetch_fire && rsp_d.hit),
    .raddr (idx[MA_W-1:0]),
    .rdata (rdata)
  );

  // Control FSM with registered handshake outputs and fetch-valid pipe.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state       <= ST_LOAD;
      wptr        <= '0;
      load_ready  <= 1'b1;
      fetch_ready <= 1'b0;
      vld_pipe    <= '0;
      if (!rst_n) rsp_q <= '0;
    end else begin
      vld_pipe[0] <= fetch_fire;
      if (fetch_fire) rsp_q <= rsp_d;
      unique case (state)
        ST_LOAD: begin
          if (load_fire) begin
            wptr <= wptr_inc;
            if (last_beat) begin
              state       <= ST_RUN;
              load_ready  <= 1'b0;
              fetch_ready <= 1'b1;
            end
          end
        end
        ST_RUN: ;
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign running     = (state == ST_RUN);
  assign prog_len    = wptr;
  assign fetch_valid = vld_pipe[STAGES-1];
  assign fetch_instr = rsp_q.hit ? rdata : NOP_WORD;
  assign fetch_err   = rsp_q.err;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomised + directed bench for instr_mem_loadable against a queue-based
// program model.
module tb_instr_mem_loadable;

  localparam int          DEPTH = 64;
  localparam int          PL_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst_n, load_valid, load_last, restart, fetch_req;
  logic [31:0]     load_data, fetch_addr;
  logic            load_ready, fetch_ready, fetch_valid, fetch_err, running;
  logic [31:0]     fetch_instr;
  logic [PL_W-1:0] prog_len;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] prog[$];
  bit          m_run, m_valid, m_err;
  logic [31:0] m_instr;
  logic [31:0] w64 [DEPTH];

  instr_mem_loadable #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .restart(restart),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .prog_len(prog_len), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_fetch(input logic [31:0] addr, output logic [31:0] instr,
                                    output bit err);
    longint unsigned i = longint'(addr >> 2);
    if (addr[1:0] != 2'b00 || i >= DEPTH) begin instr = NOP; err = 1'b1; end
    else if (i >= prog.size())            begin instr = NOP; err = 1'b0; end
    else                                  begin instr = prog[i]; err = 1'b0; end
  endfunction

  // Advance model by one clock using the currently driven inputs, then check.
  task automatic cycle();
    if (!rst_n || restart) begin
      prog.delete();
      m_run   = 1'b0;
      m_valid = 1'b0;
      if (!rst_n) begin m_instr = NOP; m_err = 1'b0; end
    end else begin
      m_valid = fetch_req && m_run;
      if (m_valid) ref_fetch(fetch_addr, m_instr, m_err);
      if (load_valid && !m_run) begin
        prog.push_back(load_data);
        if (load_last || prog.size() == DEPTH) m_run = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("load_ready",  load_ready,  !m_run && prog.size() < DEPTH);
    chk("running",     running,     m_run);
    chk("fetch_ready", fetch_ready, m_run);
    chk("prog_len",    prog_len,    prog.size());
    chk("fetch_valid", fetch_valid, m_valid);
    chk("fetch_instr", fetch_instr, m_instr);
    chk("fetch_err",   fetch_err,   m_err);
  endtask

  task automatic idle();
    rst_n = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    restart = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    load_valid = 1'b1; load_data = d; load_last = last;
    cycle();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    cycle();
    fetch_req = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1; cycle(); restart = 1'b0;
  endtask

  initial begin
    idle();
    // 1: reset
    rst_n = 1'b0; cycle(); cycle(); rst_n = 1'b1;
    chk("rst_instr", fetch_instr, 32'h0);
    cycle();

    // 2: three-word program, back-to-back fetches
    load_word(32'h8001060A, 1'b0);
    load_word(32'h04010800, 1'b0);
    load_word(32'h0C011800, 1'b1);
    chk("s2_len", prog_len, 3);
    chk("s2_run", running, 1'b1);
    fetch_req = 1'b1;
    fetch_addr = 32'h0; cycle(); chk("s2_w0", fetch_instr, 32'h8001060A);
    fetch_addr = 32'h4; cycle(); chk("s2_w1", fetch_instr, 32'h04010800);
    fetch_addr = 32'h8; cycle(); chk("s2_w2", fetch_instr, 32'h0C011800);
    fetch_req = 1'b0; cycle(); chk("s2_novld", fetch_valid, 1'b0);

    // 3: unloaded, misaligned, out-of-range
    fetch(32'h0C);  chk("s3_unl_err", fetch_err, 1'b0); chk("s3_unl", fetch_instr, NOP);
    fetch(32'h102); chk("s3_mis_err", fetch_err, 1'b1);
    fetch(32'h100); chk("s3_oor_err", fetch_err, 1'b1); chk("s3_oor", fetch_instr, NOP);

    // 4: fill all DEPTH words without load_last
    pulse_restart();
    for (int i = 0; i < DEPTH; i++) begin
      w64[i] = $urandom;
      load_word(w64[i], 1'b0);
    end
    chk("s4_run", running, 1'b1);
    chk("s4_lr", load_ready, 1'b0);
    load_word(32'hDEADBEEF, 1'b0);
    chk("s4_len", prog_len, DEPTH);
    fetch(32'hFC); chk("s4_w63", fetch_instr, w64[63]);

    // 5: restart collides with fetch_req
    fetch_req = 1'b1; fetch_addr = 32'h0; restart = 1'b1;
    cycle();
    fetch_req = 1'b0; restart = 1'b0;
    chk("s5_vld", fetch_valid, 1'b0);
    chk("s5_len", prog_len, 0);
    chk("s5_lr", load_ready, 1'b1);
    load_word(32'hA800FFFF, 1'b1);
    fetch(32'h0); chk("s5_w0", fetch_instr, 32'hA800FFFF);

    // 6: reset mid-load, then fetch during LOAD
    pulse_restart();
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b0);
    rst_n = 1'b0; load_valid = 1'b1; load_data = 32'h33333333;
    cycle();
    idle();
    chk("s6_len", prog_len, 0);
    chk("s6_run", running, 1'b0);
    fetch(32'h0); chk("s6_novld", fetch_valid, 1'b0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      restart    = ($urandom_range(0, 39) == 0);
      load_valid = $urandom_range(0, 1);
      load_data  = $urandom;
      load_last  = ($urandom_range(0, 7) == 0);
      fetch_req  = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: fetch_addr = $urandom_range(0, 15) * 4;
        1: fetch_addr = $urandom_range(0, 70) * 4;
        2: fetch_addr = ($urandom_range(0, 63) * 4) | $urandom_range(1, 3);
        default: fetch_addr = $urandom;
      endcase
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
